// File: rtl/uc_pkg.sv
// Shared unit-clause definitions: literal width, producer count and the
// literal type used by uc_arbiter and uc_queue.
package uc_pkg;

  localparam int UC_LENGTH = 16;
  localparam int UC_LIT_W  = $clog2(UC_LENGTH) + 1;
  localparam int UC_N_SRC  = 4;

  typedef logic [UC_LIT_W-1:0] lit_t;

  // Saturating increment for the 16-bit duplicate counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/uc_arbiter_rr_select.sv
// Round-robin selector: the lowest requesting index at or after ptr_i wins,
// wrapping modulo N.
module rr_select #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] winner_o,
  output logic          any_o
);

  int   idx;
  logic hit;

  // Walk the requests starting at the pointer; the first hit is the grant
  always_comb begin
    grant_o  = '0;
    winner_o = '0;
    any_o    = 1'b0;
    idx      = 0;
    hit      = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx          = (int'(ptr_i) + k) % N;
      hit          = req_i[idx] & ~any_o;
      grant_o[idx] = grant_o[idx] | hit;
      winner_o     = hit ? PW'(idx) : winner_o;
      any_o        = any_o | hit;
    end
  end

endmodule

// File: rtl/uc_arbiter.sv
// Merges unit-clause literals from several BCP engines into one uc_queue
// push stream, dropping back-to-back duplicates of the last pushed literal.
module uc_arbiter
  import uc_pkg::*;
#(
  parameter int N_SRC = UC_N_SRC,
  parameter int LIT_W = UC_LIT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [N_SRC-1:0]            src_valid,
  input  logic [N_SRC-1:0][LIT_W-1:0] src_lit,
  output logic [N_SRC-1:0]            src_ready,
  input  logic                        ucq_full,
  output logic                        push,
  output logic [LIT_W-1:0]            uca2ucq,
  output logic [15:0]                 drop_cnt
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0]            hold_v_q,   hold_v_d;
  logic [N_SRC-1:0][LIT_W-1:0] hold_lit_q, hold_lit_d;
  logic                        last_v_q,   last_v_d;
  logic [LIT_W-1:0]            last_lit_q, last_lit_d;
  logic [PW-1:0]               rr_ptr_q,   rr_ptr_d;
  logic [15:0]                 drop_cnt_q, drop_cnt_d;

  logic [N_SRC-1:0] grant_s;
  logic [PW-1:0]    winner_s;
  logic             sel_any_s;
  logic             gate_s;
  logic [N_SRC-1:0] consume_s;
  logic             consume_any_s;
  logic [LIT_W-1:0] sel_lit_s;
  logic             dup_s;
  logic [N_SRC-1:0] capture_s;

  rr_select #(.N(N_SRC), .PW(PW)) u_rr_select (
    .req_i    (hold_v_q),
    .ptr_i    (rr_ptr_q),
    .grant_o  (grant_s),
    .winner_o (winner_s),
    .any_o    (sel_any_s)
  );

  // A full queue or a flush stalls consumption; the selected literal stays held
  assign gate_s        = ~ucq_full & ~flush;
  assign consume_s     = grant_s & {N_SRC{gate_s}};
  assign consume_any_s = sel_any_s & gate_s;
  assign sel_lit_s     = sel_any_s ? hold_lit_q[winner_s] : '0;
  assign dup_s         = last_v_q & (sel_lit_s == last_lit_q);

  assign push      = consume_any_s & ~dup_s;
  assign uca2ucq   = sel_lit_s;
  assign src_ready = flush ? '0 : (~hold_v_q | consume_s);
  assign capture_s = src_valid & src_ready;
  assign drop_cnt  = drop_cnt_q;

  // Next-state: holding registers, duplicate filter, pointer and drop counter
  always_comb begin
    hold_v_d   = hold_v_q;
    hold_lit_d = hold_lit_q;
    last_v_d   = last_v_q;
    last_lit_d = last_lit_q;
    rr_ptr_d   = rr_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (flush) begin
      hold_v_d = '0;
      last_v_d = 1'b0;
      rr_ptr_d = '0;
    end else begin
      // A capture on a consumed source reloads it, so it is applied last
      hold_v_d = (hold_v_q & ~consume_s) | capture_s;
      for (int i = 0; i < N_SRC; i++) begin
        hold_lit_d[i] = capture_s[i] ? src_lit[i] : hold_lit_q[i];
      end
      if (consume_any_s) begin
        rr_ptr_d = (winner_s == PW'(N_SRC - 1)) ? '0 : winner_s + PW'(1);
        if (dup_s) begin
          drop_cnt_d = sat_inc16(drop_cnt_q);
        end else begin
          last_v_d   = 1'b1;
          last_lit_d = sel_lit_s;
        end
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q   <= '0;
      hold_lit_q <= '0;
      last_v_q   <= 1'b0;
      last_lit_q <= '0;
      rr_ptr_q   <= '0;
      drop_cnt_q <= 16'd0;
    end else begin
      hold_v_q   <= hold_v_d;
      hold_lit_q <= hold_lit_d;
      last_v_q   <= last_v_d;
      last_lit_q <= last_lit_d;
      rr_ptr_q   <= rr_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule
